// File: rtl/skinny_mode_seq.sv
// SKINNY-128-384 mode sequencer: working registers, round-constant LFSR, load/run/unload FSM.
// Optional abort port enabled by defining SKINNY_MODE_ABORT_EN.
module skinny_mode_seq #(
  parameter int BUS_W      = 32,
  parameter int UNROLL     = 2,
  parameter int NUM_ROUNDS = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_W-1:0]      din,
  input  logic [1:0]            din_sel,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [7:0]            domain,
  input  logic                  cnt_init,
  input  logic                  cnt_inc,
  output logic [55:0]           counter,
  input  logic                  start,
  output logic [127:0]          rnd_s,
  output logic [127:0]          rnd_tk1,
  output logic [127:0]          rnd_tk2,
  output logic [63:0]           rnd_tk3,
  output logic [6*UNROLL-1:0]   rnd_const,
  input  logic [127:0]          rnd_s_in,
  input  logic [127:0]          rnd_tk1_in,
  input  logic [127:0]          rnd_tk2_in,
  input  logic [63:0]           rnd_tk3_in,
  output logic [BUS_W-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
`ifdef SKINNY_MODE_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  done
);

  localparam int BEATS = 128 / BUS_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW   = $clog2(NUM_ROUNDS + 1);

  localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);
  localparam logic [RCW-1:0] RC_STEP   = RCW'(UNROLL);
  localparam logic [RCW-1:0] RC_END    = RCW'(NUM_ROUNDS);

  if ((NUM_ROUNDS % UNROLL) != 0) begin : g_bad_rounds
    $error("NUM_ROUNDS must be a multiple of UNROLL");
  end
  if ((128 % BUS_W) != 0) begin : g_bad_bus
    $error("BUS_W must divide 128");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } fsm_t;

  fsm_t             r_fsm;
  logic [127:0]     r_s;
  logic [127:0]     r_tk1;
  logic [127:0]     r_tk2;
  logic [63:0]      r_tk3;
  logic [55:0]      r_cnt;
  logic [5:0]       r_rc;
  logic [RCW-1:0]   r_rcnt;
  logic [BW-1:0]    r_beat;
  logic             r_done;

  logic [127+BUS_W:0] w_s_cat;
  logic [127+BUS_W:0] w_tk1_cat;
  logic [127+BUS_W:0] w_tk2_cat;
  logic [55:0]        w_cnt_step;
  logic [RCW-1:0]     w_rcnt_nxt;
  logic [5:0]         w_rc_nxt;
  logic [6*UNROLL-1:0] w_const;

  function automatic logic [5:0] f_rc(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4] ^ 1'b1};
  endfunction

  // Each unrolled round k consumes the (k+1)-th LFSR step from r_rc.
  always_comb begin
    w_rc_nxt = r_rc;
    w_const  = '0;
    for (int k = 0; k < UNROLL; k++) begin
      w_rc_nxt          = f_rc(w_rc_nxt);
      w_const[6*k +: 6] = w_rc_nxt;
    end
  end

  assign w_s_cat    = {r_s, din};
  assign w_tk1_cat  = {r_tk1, din};
  assign w_tk2_cat  = {r_tk2, din};
  assign w_cnt_step = {r_cnt[54:0], 1'b0}
                    ^ (r_cnt[55] ? 56'h95 : 56'h0);
  assign w_rcnt_nxt = r_rcnt + RC_STEP;

  assign din_ready  = (r_fsm == IDLE) & ~start;
  assign busy       = (r_fsm != IDLE);
  assign dout_valid = (r_fsm == UNLOAD);
  assign dout       = r_s[127 -: BUS_W];
  assign done       = r_done;
  assign counter    = r_cnt;
  assign rnd_s      = r_s;
  assign rnd_tk1    = r_tk1;
  assign rnd_tk2    = r_tk2;
  assign rnd_tk3    = r_tk3;
  assign rnd_const  = w_const;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm  <= IDLE;
      r_s    <= '0;
      r_tk1  <= '0;
      r_tk2  <= '0;
      r_tk3  <= '0;
      r_cnt  <= 56'h1;
      r_rc   <= '0;
      r_rcnt <= '0;
      r_beat <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_fsm)
        IDLE: begin
          if (start) begin
            r_tk3  <= {r_cnt, domain};
            r_rc   <= '0;
            r_rcnt <= '0;
            r_beat <= '0;
            r_fsm  <= RUN;
          end else if (din_valid) begin
            unique case (din_sel)
              2'd0: r_s   <= w_s_cat[127:0];
              2'd1: r_tk1 <= w_tk1_cat[127:0];
              2'd2: r_tk2 <= w_tk2_cat[127:0];
              2'd3: ;
            endcase
          end
          if (cnt_init) begin
            r_cnt <= 56'h1;
          end else if (cnt_inc) begin
            r_cnt <= w_cnt_step;
          end
        end
        RUN: begin
          r_s    <= rnd_s_in;
          r_tk1  <= rnd_tk1_in;
          r_tk2  <= rnd_tk2_in;
          r_tk3  <= rnd_tk3_in;
          r_rc   <= w_rc_nxt;
          r_rcnt <= w_rcnt_nxt;
          if (w_rcnt_nxt == RC_END) begin
            r_fsm  <= UNLOAD;
            r_done <= 1'b1;
          end
        end
        UNLOAD: begin
          if (dout_ready) begin
            r_s    <= r_s << BUS_W;
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) begin
              r_fsm <= IDLE;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
`ifdef SKINNY_MODE_ABORT_EN
      // Abort overrides any RUN commit or UNLOAD handshake this cycle.
      if (abort && (r_fsm != IDLE)) begin
        r_fsm  <= IDLE;
        r_s    <= '0;
        r_done <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_skinny_mode_seq.sv
// Directed testbench for skinny_mode_seq (BUS_W=32, UNROLL=2, 40 rounds).
// Round unit modelled as identity or an 8-bit left rotation of S.
module tb_skinny_mode_seq;

  localparam int BUS_W  = 32;
  localparam int UNROLL = 2;
  localparam int NR     = 40;

  localparam logic [127:0] A  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] B  = 128'hA5A5A5A5_5A5A5A5A_01020304_F0E0D0C0;
  localparam logic [127:0] K1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] K2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [BUS_W-1:0]     din = '0;
  logic [1:0]           din_sel = '0;
  logic                 din_valid = 1'b0;
  logic                 din_ready;
  logic [7:0]           domain = '0;
  logic                 cnt_init = 1'b0;
  logic                 cnt_inc = 1'b0;
  logic [55:0]          counter;
  logic                 start = 1'b0;
  logic [127:0]         rnd_s, rnd_tk1, rnd_tk2;
  logic [63:0]          rnd_tk3;
  logic [6*UNROLL-1:0]  rnd_const;
  logic [127:0]         rnd_s_in, rnd_tk1_in, rnd_tk2_in;
  logic [63:0]          rnd_tk3_in;
  logic [BUS_W-1:0]     dout;
  logic                 dout_valid;
  logic                 dout_ready = 1'b0;
  logic                 busy;
  logic                 done;
`ifdef SKINNY_MODE_ABORT_EN
  logic                 abort = 1'b0;
`endif

  logic rot_mode = 1'b0;
  int   checks = 0;
  int   errors = 0;

  assign rnd_s_in   = rot_mode ? {rnd_s[119:0], rnd_s[127:120]} : rnd_s;
  assign rnd_tk1_in = rnd_tk1;
  assign rnd_tk2_in = rnd_tk2;
  assign rnd_tk3_in = rnd_tk3;

  always #5 clk = ~clk;

  skinny_mode_seq #(
    .BUS_W(BUS_W), .UNROLL(UNROLL), .NUM_ROUNDS(NR)
  ) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_sel(din_sel), .din_valid(din_valid),
    .din_ready(din_ready), .domain(domain),
    .cnt_init(cnt_init), .cnt_inc(cnt_inc), .counter(counter),
    .start(start),
    .rnd_s(rnd_s), .rnd_tk1(rnd_tk1), .rnd_tk2(rnd_tk2),
    .rnd_tk3(rnd_tk3), .rnd_const(rnd_const),
    .rnd_s_in(rnd_s_in), .rnd_tk1_in(rnd_tk1_in),
    .rnd_tk2_in(rnd_tk2_in), .rnd_tk3_in(rnd_tk3_in),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy),
`ifdef SKINNY_MODE_ABORT_EN
    .abort(abort),
`endif
    .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [1:0] sel, input logic [127:0] v);
    for (int i = 0; i < 4; i++) begin
      din       = v[127-32*i -: 32];
      din_sel   = sel;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (counter !== 56'h1) begin
      errors++;
      $display("FAIL reset_counter: got %h exp %h", counter, 56'h1);
    end
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b dv=%b done=%b exp 0 0 0",
               busy, dout_valid, done);
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_din_ready: got %b exp 1", din_ready);
    end
    checks++;
    if (rnd_s !== 128'h0 || rnd_tk3 !== 64'h0) begin
      errors++;
      $display("FAIL reset_regs: s=%h tk3=%h exp 0", rnd_s, rnd_tk3);
    end
  endtask

  task automatic test_load_run;
    int n;
    logic [31:0] w;
    load4(2'd0, A);
    checks++;
    if (rnd_s !== A) begin
      errors++;
      $display("FAIL load_s: got %h exp %h", rnd_s, A);
    end
    domain = 8'h5A;
    start  = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_din_ready: got %b exp 0", din_ready);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || rnd_tk3 !== {56'h1, 8'h5A}) begin
      errors++;
      $display("FAIL run_entry: busy=%b tk3=%h exp 1 %h",
               busy, rnd_tk3, {56'h1, 8'h5A});
    end
    checks++;
    if (rnd_const !== 12'h0C1) begin
      errors++;
      $display("FAIL const_c1: got %h exp %h", rnd_const, 12'h0C1);
    end
    tick();
    checks++;
    if (rnd_const !== 12'h3C7) begin
      errors++;
      $display("FAIL const_c2: got %h exp %h", rnd_const, 12'h3C7);
    end
    tick();
    checks++;
    if (rnd_const !== 12'hF9F) begin
      errors++;
      $display("FAIL const_c3: got %h exp %h", rnd_const, 12'hF9F);
    end
    n = 2;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 20 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL done_latency: got %0d dv=%b exp 20 1", n, dout_valid);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = A[127-32*i -: 32];
      checks++;
      if (dout !== w) begin
        errors++;
        $display("FAIL unload_beat%0d: got %h exp %h", i, dout, w);
      end
      if (i == 1) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: got %b exp 0", done);
        end
      end
      tick();
    end
    dout_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL unload_end: busy=%b dv=%b dr=%b exp 0 0 1",
               busy, dout_valid, din_ready);
    end
  endtask

  task automatic test_counter;
    cnt_inc = 1'b1;
    tick();
    cnt_inc = 1'b0;
    checks++;
    if (counter !== 56'h2) begin
      errors++;
      $display("FAIL cnt_inc1: got %h exp %h", counter, 56'h2);
    end
    cnt_init = 1'b1;
    tick();
    cnt_init = 1'b0;
    checks++;
    if (counter !== 56'h1) begin
      errors++;
      $display("FAIL cnt_init: got %h exp %h", counter, 56'h1);
    end
    cnt_inc = 1'b1;
    repeat (55) tick();
    checks++;
    if (counter !== 56'h80000000000000) begin
      errors++;
      $display("FAIL cnt_inc55: got %h exp %h", counter, 56'h80000000000000);
    end
    tick();
    cnt_inc = 1'b0;
    checks++;
    if (counter !== 56'h95) begin
      errors++;
      $display("FAIL cnt_inc56: got %h exp %h", counter, 56'h95);
    end
    cnt_init = 1'b1;
    cnt_inc  = 1'b1;
    tick();
    cnt_init = 1'b0;
    cnt_inc  = 1'b0;
    checks++;
    if (counter !== 56'h1) begin
      errors++;
      $display("FAIL cnt_prio: got %h exp %h", counter, 56'h1);
    end
  endtask

  task automatic test_stall;
    int n;
    int idx;
    logic [31:0] w;
    load4(2'd1, K1);
    load4(2'd0, A);
    rot_mode = 1'b1;
    start    = 1'b1;
    tick();
    start     = 1'b0;
    din       = 32'hFFFF_FFFF;
    din_sel   = 2'd1;
    din_valid = 1'b1;
    cnt_inc   = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    din_valid = 1'b0;
    cnt_inc   = 1'b0;
    rot_mode  = 1'b0;
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL stall_latency: got %0d exp 20", n);
    end
    // 20 rotations by 8 bits leave S rotated left by one word.
    dout_ready = 1'b1;
    w = A[95:64];
    checks++;
    if (dout !== w) begin
      errors++;
      $display("FAIL rot_beat0: got %h exp %h", dout, w);
    end
    tick();
    dout_ready = 1'b0;
    w = A[63:32];
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dout !== w || dout_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: dout=%h dv=%b busy=%b exp %h 1 1",
                 i, dout, dout_valid, busy, w);
      end
      tick();
    end
    dout_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      idx = (j + 1) % 4;
      w = A[127-32*idx -: 32];
      checks++;
      if (dout !== w) begin
        errors++;
        $display("FAIL rot_beat%0d: got %h exp %h", j, dout, w);
      end
      tick();
    end
    dout_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_end_busy: got %b exp 0", busy);
    end
    checks++;
    if (rnd_tk1 !== K1 || counter !== 56'h1) begin
      errors++;
      $display("FAIL busy_ignore: tk1=%h cnt=%h exp %h %h",
               rnd_tk1, counter, K1, 56'h1);
    end
  endtask

  task automatic test_start_din;
    cnt_inc = 1'b1;
    tick();
    cnt_inc = 1'b0;
    load4(2'd0, B);
    domain    = 8'h3C;
    din       = 32'hFFFF_FFFF;
    din_sel   = 2'd0;
    din_valid = 1'b1;
    start     = 1'b1;
    tick();
    din_valid = 1'b0;
    start     = 1'b0;
    checks++;
    if (rnd_s !== B || rnd_tk3 !== {56'h2, 8'h3C}) begin
      errors++;
      $display("FAIL start_beat_drop: s=%h tk3=%h exp %h %h",
               rnd_s, rnd_tk3, B, {56'h2, 8'h3C});
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rst_flags: busy=%b dv=%b done=%b exp 0 0 0",
               busy, dout_valid, done);
    end
    checks++;
    if (rnd_s !== 128'h0 || rnd_tk1 !== 128'h0 ||
        rnd_tk2 !== 128'h0 || rnd_tk3 !== 64'h0) begin
      errors++;
      $display("FAIL midrun_rst_regs: s=%h tk1=%h tk3=%h exp 0",
               rnd_s, rnd_tk1, rnd_tk3);
    end
    checks++;
    if (counter !== 56'h1 || rnd_const !== 12'h0C1) begin
      errors++;
      $display("FAIL midrun_rst_cnt: cnt=%h const=%h exp %h %h",
               counter, rnd_const, 56'h1, 12'h0C1);
    end
    tick();
  endtask

`ifdef SKINNY_MODE_ABORT_EN
  task automatic test_abort;
    logic seen;
    load4(2'd1, K1);
    load4(2'd2, K2);
    cnt_inc = 1'b1;
    tick();
    cnt_inc = 1'b0;
    load4(2'd0, A);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || rnd_s !== 128'h0) begin
      errors++;
      $display("FAIL abort_state: busy=%b s=%h exp 0 0", busy, rnd_s);
    end
    checks++;
    if (rnd_tk1 !== K1 || rnd_tk2 !== K2 || counter !== 56'h2) begin
      errors++;
      $display("FAIL abort_keep: tk1=%h tk2=%h cnt=%h exp %h %h %h",
               rnd_tk1, rnd_tk2, counter, K1, K2, 56'h2);
    end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got %b exp 0", seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_run();
    test_counter();
    test_stall();
    test_start_din();
`ifdef SKINNY_MODE_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skinny_mode_seq.md
Name: skinny_mode_seq

Overview:
- Parametrised successor to the fixed 32-bit, 2-rounds-per-cycle Romulus mode datapath.
- Owns the SKINNY-128-384 working registers: state S, TK1, TK2, TK3 and the 56-bit block counter.
- Owns the round-constant LFSR and a load/run/unload FSM with valid/ready handshakes.
- Drives an external combinational round unit of UNROLL rounds per cycle and registers its results.

Parameters:
BUS_W, 32, load/unload beat width; one of 8, 16, 32, 64, 128 (divides 128).
UNROLL, 2, rounds committed per RUN cycle; one of 1, 2, 4, 5, 8.
NUM_ROUNDS, 40, total rounds; must be a multiple of UNROLL (elaboration error otherwise).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
din  in  BUS_W  load data, MSB-first.
din_sel  in  2  0=S, 1=TK1, 2=TK2, 3=ignored (beat consumed, no write).
din_valid  in  1  load beat valid.
din_ready  out  1  = (fsm==IDLE) & ~start.
domain  in  8  domain byte packed into TK3.
cnt_init  in  1  counter := 56'h1 (IDLE only).
cnt_inc  in  1  counter := LFSR step (IDLE only).
counter  out  56  current block counter.
start  in  1  begin encryption (IDLE only).
rnd_s, rnd_tk1, rnd_tk2  out  128 each  current working registers to the round unit.
rnd_tk3  out  64  TK3 working register.
rnd_const  out  6*UNROLL  round constants; slice k = [6k+5:6k] is round i+k.
rnd_s_in, rnd_tk1_in, rnd_tk2_in  in  128 each  round-unit results after UNROLL rounds.
rnd_tk3_in  in  64  TK3 result after UNROLL rounds.
dout  out  BUS_W  = S[127:128-BUS_W].
dout_valid  out  1  high in UNLOAD.
dout_ready  in  1  unload beat accept.
busy  out  1  fsm != IDLE.
done  out  1  one-cycle pulse on entry to UNLOAD.

Behaviour:
- Reset: fsm=IDLE; S, TK1, TK2, TK3 = 0; counter = 56'h1; rc = 0; round count = 0.
  - Outputs after reset: done=0, dout_valid=0, busy=0.
- Reset mid-RUN or mid-UNLOAD: same values on the next edge; no partial unload.
- FSM states: IDLE -> RUN -> UNLOAD -> IDLE.
- IDLE load:
  - On din_valid & din_ready, the selected 128-bit register shifts: reg <= {reg[127-BUS_W:0], din}.
  - 128/BUS_W beats fill a register.
- IDLE counter:
  - cnt_init has priority over cnt_inc.
  - Step: c' = {c[54:0],1'b0} ^ (c[55] ? 56'h95 : 0).
  - cnt_init/cnt_inc are ignored outside IDLE.
- start in IDLE (same-cycle load beat is not accepted, because din_ready=0):
  - TK3 <= {counter, domain}; rc <= 0; round count <= 0; fsm <= RUN.
- RUN, every cycle:
  - S, TK1, TK2, TK3 <= rnd_*_in.
  - rc <= f^UNROLL(rc), where f(x) = {x[4:0], x[5]^x[4]^1'b1}.
  - rnd_const slice k = f^(k+1)(rc). Sequence from rc=0: 01, 03, 07, 0F, 1F, 3E, 3D, 3B, ...
  - Round count += UNROLL; when it reaches NUM_ROUNDS, fsm <= UNLOAD.
  - Exactly NUM_ROUNDS/UNROLL RUN cycles.
- Latency: start sampled at edge t; done=1 in the cycle after edge t+NUM_ROUNDS/UNROLL.
- UNLOAD:
  - dout_valid=1; on dout_ready, S <= S<<BUS_W.
  - After beat 128/BUS_W is accepted: fsm <= IDLE, dout_valid drops the same edge.
  - dout_ready low stalls indefinitely, holding dout stable.
- start, din_valid, cnt_* are ignored while busy.
- TK1, TK2, counter are not reloaded by the FSM; firmware reloads keys per block.

Optional Feature:
Macro: SKINNY_MODE_ABORT_EN.
- Defined: extra input port abort (1 bit).
  - In RUN or UNLOAD, abort -> fsm <= IDLE at the next edge and S <= 0; TK/counter are preserved.
  - done is not asserted; abort beats UNLOAD handshake completion in the same cycle.
  - abort is ignored in IDLE.
- Undefined: no abort port; RUN/UNLOAD always complete.

Test Plan:
- Reset, then idle 5 cycles -> counter=56'h1, busy=0, dout_valid=0, din_ready=1.
- BUS_W=32: four beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with sel=0, then start.
  - Round unit as identity: rnd_const slices in cycles 1..3 are {03,01}, {0F,07}, {3E,1F}.
  - done asserts exactly 20 cycles after start; 4 unload beats return the loaded words in order.
- Counter: cnt_init, then 56 cnt_inc -> counter=56'h95; simultaneous cnt_init & cnt_inc -> 56'h1.
- Hold dout_ready low 10 cycles in UNLOAD -> dout stable, fsm stays UNLOAD; release -> remaining beats, then busy=0.
- start asserted with din_valid=1 -> beat not written (din_ready=0); rst mid-RUN -> all registers at reset values next cycle.
- SKINNY_MODE_ABORT_EN: abort at RUN cycle 7 -> busy=0 next cycle, S=0, TK1/TK2/counter unchanged, done never pulses.
